// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache: FSM states and
// address-split width helpers derived from NUM_LINES / LINE_WORDS.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_RESUME    = 2'd3
  } state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  // Bits of a backing-memory line
  function automatic int calc_line_w(input int line_words);
    return WORD_W * line_words;
  endfunction

  // Byte-offset bits within a line (word select plus the two byte bits)
  function automatic int calc_offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int calc_index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int calc_tag_w(input int num_lines, input int line_words);
    return ADDR_W - calc_index_w(num_lines) - calc_offset_w(line_words);
  endfunction

  // Word-select width; kept at least 1 bit so single-word lines stay legal
  function automatic int calc_wsel_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one combinational read port,
// one posedge write port that updates either a single word or a whole line.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4,
  localparam int LINE_W    = calc_line_w(LINE_WORDS),
  localparam int INDEX_W   = calc_index_w(NUM_LINES),
  localparam int TAG_W     = calc_tag_w(NUM_LINES, LINE_WORDS),
  localparam int WSEL_W    = calc_wsel_w(LINE_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [INDEX_W-1:0] i_index,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_word_we,
  input  logic [WSEL_W-1:0] i_word_sel,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_line_we,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [LINE_W-1:0] i_line_data
);

  logic [TAG_W-1:0]     r_tag   [NUM_LINES];
  logic [LINE_W-1:0]    r_data  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign o_tag   = r_tag[i_index];
  assign o_line  = r_data[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];

  // A line fill always leaves the line clean; a word store marks it dirty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // NOTE: data/tag arrays carry no reset; valid bits gate every use, and a
  // reset on the bulk arrays would stop them mapping onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_data[i_index] <= i_line_data;
      r_tag[i_index]  <= i_line_tag;
    end else if (i_word_we) begin
      r_data[i_index][{i_word_sel, 5'd0} +: WORD_W] <= i_word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit logic,
// miss FSM and line transfers. Define DCACHE_STATS_EN to add hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4,
  localparam int LINE_W    = calc_line_w(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
`endif
);

  localparam int OFFSET_W = calc_offset_w(LINE_WORDS);
  localparam int INDEX_W  = calc_index_w(NUM_LINES);
  localparam int TAG_W    = calc_tag_w(NUM_LINES, LINE_WORDS);
  localparam int WSEL_W   = calc_wsel_w(LINE_WORDS);

  state_e              r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [LINE_W-1:0]   r_mem_data;

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [WSEL_W-1:0]   w_word_sel;
  logic [TAG_W-1:0]    w_rd_tag;
  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic [LINE_W-1:0]   w_rd_line;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_idle;
  logic                w_req;
  logic                w_hit;
  logic                w_miss;
  logic                w_word_we;
  logic                w_line_we;

  assign w_index    = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign w_tag      = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_word_sel = WSEL_W'((cpu_addr_i >> 2) & 32'(LINE_WORDS - 1));

  dcache_sram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_sram (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_index     (w_index),
    .o_tag       (w_rd_tag),
    .o_valid     (w_rd_valid),
    .o_dirty     (w_rd_dirty),
    .o_line      (w_rd_line),
    .i_word_we   (w_word_we),
    .i_word_sel  (w_word_sel),
    .i_word_data (cpu_data_i),
    .i_line_we   (w_line_we),
    .i_line_tag  (w_tag),
    .i_line_data (mem_data_i)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign w_req     = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
  assign w_miss    = w_idle && w_req && !w_hit;
  assign w_rd_word = w_rd_line[{w_word_sel, 5'd0} +: WORD_W];

  // Read+write together is a store, so no load data is returned for it.
  assign cpu_data_o  = (w_idle && cpu_MemRead_i && !cpu_MemWrite_i && w_hit) ? w_rd_word : '0;
  assign cpu_stall_o = !w_idle || w_miss;

  // Writes are suppressed under reset so an ack racing the reset cannot fill a line.
  assign w_word_we = w_idle && cpu_MemWrite_i && w_hit && !rst_i;
  assign w_line_we = (r_state == ST_ALLOCATE) && mem_ack_i && !rst_i;

  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_mem_we;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // reader sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_mem_req <= 1'b1;
            if (w_rd_valid && w_rd_dirty) begin
              r_state    <= ST_WRITEBACK;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {w_rd_tag, w_index, {OFFSET_W{1'b0}}};
              r_mem_data <= w_rd_line;
            end else begin
              r_state    <= ST_ALLOCATE;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
              r_mem_data <= '0;
            end
          end
        end
        ST_WRITEBACK: begin
          // Request stays high; the fetch begins in the cycle after the ack.
          if (mem_ack_i) begin
            r_state    <= ST_ALLOCATE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
            r_mem_data <= '0;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state    <= ST_RESUME;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
          end
        end
        ST_RESUME: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_after_resume;

  // The hit that completes a refilled request was already counted as a miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_count    <= '0;
      r_miss_count   <= '0;
      r_after_resume <= 1'b0;
    end else begin
      r_after_resume <= (r_state == ST_RESUME);
      if (w_idle && w_req) begin
        if (!w_hit) begin
          r_miss_count <= r_miss_count + 32'd1;
        end else if (!r_after_resume) begin
          r_hit_count <= r_hit_count + 32'd1;
        end
      end
    end
  end

  assign hit_count_o  = r_hit_count;
  assign miss_count_o = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a fixed-latency line memory.
// Stats checks run only when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

  localparam logic [127:0] LINE040 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h00C0_FFEE};
  localparam logic [127:0] LINE240 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
  localparam logic [127:0] LINE080 = {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;
  logic         model_ack;
  logic         stray_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 3;
  int mem_cnt = 0;
  int tx_n = 0;
  logic         tx_we   [0:15];
  logic [31:0]  tx_addr [0:15];
  logic [127:0] tx_data [0:15];

  assign mem_ack_i = model_ack | stray_ack;

  dcache_ctrl #(.NUM_LINES(32), .LINE_WORDS(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o    (hit_count_o),
    .miss_count_o   (miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] fetch_line(input logic [31:0] a);
    case (a)
      32'h0000_0040: return LINE040;
      32'h0000_0240: return LINE240;
      32'h0000_0080: return LINE080;
      default:       return {4{a}};
    endcase
  endfunction

  // Backing memory: acks the mem_lat-th cycle of each request and logs it.
  always @(negedge clk_i) begin
    model_ack = 1'b0;
    if (mem_req_o) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        model_ack  = 1'b1;
        mem_data_i = fetch_line(mem_addr_o);
        if (tx_n < 16) begin
          tx_we[tx_n]   = mem_we_o;
          tx_addr[tx_n] = mem_addr_o;
          tx_data[tx_n] = mem_data_o;
        end
        tx_n++;
        mem_cnt = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic do_access(input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] d, output int stalls, output logic [31:0] rdata);
    stalls = 0;
    @(negedge clk_i);
    cpu_addr_i = a; cpu_MemRead_i = r; cpu_MemWrite_i = w; cpu_data_i = d;
    #1;
    while (cpu_stall_o && stalls < 40) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL access_timeout addr=%h: stall still %b after %0d cycles", a, cpu_stall_o, stalls);
    end
    rdata = cpu_data_o;
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    checks++; if (mem_data_o !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data_o); end
    checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_data: got %h want 0", cpu_data_o); end
  endtask

  task automatic test_read_miss();
    int st; logic [31:0] rd; int t0;
    mem_lat = 3; t0 = tx_n;
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL miss_stall_cycles: got %0d want 5", st); end
    checks++; if (tx_n - t0 !== 1) begin errors++; $display("FAIL miss_tx_count: got %0d want 1", tx_n - t0); end
    checks++; if (tx_we[t0] !== 1'b0) begin errors++; $display("FAIL miss_fetch_we: got %b want 0", tx_we[t0]); end
    checks++; if (tx_addr[t0] !== 32'h40) begin errors++; $display("FAIL miss_fetch_addr: got %h want 00000040", tx_addr[t0]); end
    checks++; if (rd !== 32'h00C0_FFEE) begin errors++; $display("FAIL miss_read_data: got %h want 00c0ffee", rd); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL miss_req_dropped: got %b want 0", mem_req_o); end
  endtask

  task automatic test_write_hit();
    int st; logic [31:0] rd; int t0;
    t0 = tx_n;
    do_access(32'h44, 1'b0, 1'b1, 32'hDEAD_BEEF, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL wr_hit_stall: got %0d want 0", st); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_hit_cpu_data: got %h want 0", rd); end
    do_access(32'h44, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL rd_hit_stall: got %0d want 0", st); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: got %h want deadbeef", rd); end
    checks++; if (tx_n !== t0) begin errors++; $display("FAIL hit_no_mem_tx: got %0d want %0d", tx_n, t0); end
  endtask

  task automatic test_stray_ack();
    int st; logic [31:0] rd;
    go_idle();
    @(negedge clk_i); stray_ack = 1'b1;
    @(negedge clk_i); stray_ack = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stray_ack_req: got %b want 0", mem_req_o); end
    checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL stray_ack_stall: got %b want 0", cpu_stall_o); end
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (rd !== 32'h00C0_FFEE || st !== 0) begin errors++; $display("FAIL stray_ack_rehit: got %h/%0d want 00c0ffee/0", rd, st); end
  endtask

  task automatic test_dirty_evict();
    int st; logic [31:0] rd; int t0;
    mem_lat = 2; t0 = tx_n;
    do_access(32'h240, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (st !== 6) begin errors++; $display("FAIL evict_stall_cycles: got %0d want 6", st); end
    checks++; if (tx_n - t0 !== 2) begin errors++; $display("FAIL evict_tx_count: got %0d want 2", tx_n - t0); end
    checks++; if (tx_we[t0] !== 1'b1) begin errors++; $display("FAIL evict_wb_we: got %b want 1", tx_we[t0]); end
    checks++; if (tx_addr[t0] !== 32'h40) begin errors++; $display("FAIL evict_wb_addr: got %h want 00000040", tx_addr[t0]); end
    checks++;
    if (tx_data[t0] !== {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h00C0_FFEE}) begin
      errors++; $display("FAIL evict_wb_data: got %h want 3333333322222222deadbeef00c0ffee", tx_data[t0]);
    end
    checks++; if (tx_we[t0+1] !== 1'b0) begin errors++; $display("FAIL evict_fetch_we: got %b want 0", tx_we[t0+1]); end
    checks++; if (tx_addr[t0+1] !== 32'h240) begin errors++; $display("FAIL evict_fetch_addr: got %h want 00000240", tx_addr[t0+1]); end
    checks++; if (rd !== 32'h4444_0000) begin errors++; $display("FAIL evict_read_data: got %h want 44440000", rd); end
  endtask

  task automatic test_read_write_together();
    int st; logic [31:0] rd; int t0;
    t0 = tx_n;
    do_access(32'h248, 1'b1, 1'b1, 32'h1234_5678, st, rd);
    checks++; if (st !== 0) begin errors++; $display("FAIL rw_stall: got %0d want 0", st); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rw_cpu_data: got %h want 0", rd); end
    do_access(32'h248, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rw_readback: got %h want 12345678", rd); end
    checks++; if (tx_n !== t0) begin errors++; $display("FAIL rw_no_mem_tx: got %0d want %0d", tx_n, t0); end
    // Evicting 0x240 proves the combined access set the dirty bit.
    mem_lat = 1; t0 = tx_n;
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (st !== 4) begin errors++; $display("FAIL rw_evict_stall: got %0d want 4", st); end
    checks++; if (tx_n - t0 !== 2 || tx_we[t0] !== 1'b1 || tx_addr[t0] !== 32'h240) begin
      errors++; $display("FAIL rw_evict_wb: got n=%0d we=%b addr=%h want n=2 we=1 addr=00000240", tx_n - t0, tx_we[t0], tx_addr[t0]);
    end
    checks++;
    if (tx_data[t0] !== {32'h4444_0003, 32'h1234_5678, 32'h4444_0001, 32'h4444_0000}) begin
      errors++; $display("FAIL rw_evict_data: got %h want 44440003123456784444000144440000", tx_data[t0]);
    end
    checks++; if (rd !== 32'h00C0_FFEE) begin errors++; $display("FAIL rw_refetch_data: got %h want 00c0ffee", rd); end
  endtask

  task automatic test_reset_mid_miss();
    int st; logic [31:0] rd;
    mem_lat = 3;
    go_idle();
    @(negedge clk_i);
    cpu_addr_i = 32'h80; cpu_MemRead_i = 1'b1;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rst_miss_stall_now: got %b want 1", cpu_stall_o); end
    @(negedge clk_i); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h80) begin
      errors++; $display("FAIL rst_alloc_req: got req=%b we=%b addr=%h want 1/0/00000080", mem_req_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; cpu_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_abort_req: got %b want 0", mem_req_o); end
    checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL rst_abort_stall: got %b want 0", cpu_stall_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_abort_addr: got %h want 0", mem_addr_o); end
    @(negedge clk_i);
    cpu_addr_i = 32'h80; cpu_MemRead_i = 1'b1;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rst_reread_miss: got %b want 1", cpu_stall_o); end
    do_access(32'h80, 1'b1, 1'b0, 32'h0, st, rd);
    checks++; if (rd !== 32'h8888_0000) begin errors++; $display("FAIL rst_reread_data: got %h want 88880000", rd); end
    // The line at 0x40 was valid before reset and must miss now.
    go_idle();
    @(negedge clk_i);
    cpu_addr_i = 32'h40; cpu_MemRead_i = 1'b1;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rst_valid_cleared: got %b want 1", cpu_stall_o); end
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd);
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st; logic [31:0] rd;
    go_idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      errors++; $display("FAIL stats_reset: got hit=%0d miss=%0d want 0/0", hit_count_o, miss_count_o);
    end
    mem_lat = 2;
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd);
    do_access(32'h44, 1'b1, 1'b0, 32'h0, st, rd);
    do_access(32'h48, 1'b0, 1'b1, 32'h5555_AAAA, st, rd);
    go_idle();
    #1;
    checks++; if (hit_count_o !== 32'd2) begin errors++; $display("FAIL stats_hits: got %0d want 2", hit_count_o); end
    checks++; if (miss_count_o !== 32'd1) begin errors++; $display("FAIL stats_misses: got %0d want 1", miss_count_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    mem_data_i = '0; model_ack = 1'b0; stray_ack = 1'b0;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_stray_ack();
    test_dirty_evict();
    test_read_write_together();
    test_reset_mid_miss();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    go_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
